// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer: load-use / branch-operand hazard detection, PC/IF-ID stall and flush control,
// stall-cycle counter. Define ID_HAZARD_IRQ_EN to build the interrupt entry/return FSM (epc, kernel, irq_ack).
module id_hazard_ctrl #(
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rsaddrID,
    input  logic [4:0]           rtaddrID,
    input  logic                 BranchID,
    input  logic                 JumpID,
    input  logic [2:0]           PCSrcID,
    input  logic                 EretID,
    input  logic [31:0]          PCplus4ID,
    input  logic                 MemReadEX,
    input  logic                 RegWriteEX,
    input  logic [4:0]           regwriteaddrEX,
    input  logic                 MemReadMEM,
    input  logic [4:0]           regwriteaddrMEM,
    input  logic                 irq,
    output logic                 stall,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic [1:0]           pc_sel,
    output logic [31:0]          epc,
    output logic                 kernel,
    output logic                 irq_ack,
    output logic [CNT_WIDTH-1:0] stall_count
);
    logic exMatch;
    logic memMatch;
    logic loadUse;
    logic brEx;
    logic brMem;
    logic haz;
    logic irqTake;
    logic eretTake;
    logic [CNT_WIDTH-1:0] stallCountReg;

    // Register $0 never creates a dependency, so a zero destination cannot match.
    assign exMatch  = (regwriteaddrEX != 5'd0) &&
                      ((regwriteaddrEX == rsaddrID) || (regwriteaddrEX == rtaddrID));
    assign memMatch = (regwriteaddrMEM != 5'd0) &&
                      ((regwriteaddrMEM == rsaddrID) || (regwriteaddrMEM == rtaddrID));

    assign loadUse = MemReadEX & exMatch;
    assign brEx    = (BranchID | JumpID) & RegWriteEX & exMatch;
    assign brMem   = BranchID & MemReadMEM & memMatch;
    assign haz     = loadUse | brEx | brMem;

`ifdef ID_HAZARD_IRQ_EN
    typedef enum logic {RUN, KERNEL} state_t;
    state_t      stateReg;
    logic [31:0] epcReg;
    logic        unusedCfg;

    assign irqTake  = (stateReg == RUN) && irq && !haz && !BranchID && !JumpID;
    assign eretTake = (stateReg == KERNEL) && EretID && !haz;

    // The instruction sitting in ID is squashed on entry, so it is the one that restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= RUN;
            epcReg   <= 32'd0;
        end else begin
            case (stateReg)
                RUN: begin
                    if (irqTake) begin
                        epcReg   <= PCplus4ID - 32'd4;
                        stateReg <= KERNEL;
                    end
                end
                KERNEL: begin
                    if (eretTake) stateReg <= RUN;
                end
                default: stateReg <= RUN;
            endcase
        end
    end

    assign epc       = epcReg;
    assign kernel    = (stateReg == KERNEL);
    assign unusedCfg = ^IRQ_VECTOR;
`else
    logic unusedCfg;

    assign irqTake   = 1'b0;
    assign eretTake  = 1'b0;
    assign epc       = 32'd0;
    assign kernel    = 1'b0;
    assign unusedCfg = ^{IRQ_VECTOR, PCplus4ID, irq, EretID};
`endif

    // Priority: hazard hold, then interrupt entry / return, then taken-branch/jump squash.
    always_comb begin
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pc_sel     = 2'd0;
        irq_ack    = 1'b0;
        if (haz) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (irqTake) begin
            stall      = 1'b1;
            ifid_flush = 1'b1;
            pc_sel     = 2'd1;
            irq_ack    = 1'b1;
        end else if (eretTake) begin
            ifid_flush = 1'b1;
            pc_sel     = 2'd2;
        end else if (PCSrcID != 3'd0) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCountReg <= '0;
        end else if (haz && (stallCountReg != {CNT_WIDTH{1'b1}})) begin
            stallCountReg <= stallCountReg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign stall_count = stallCountReg;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: each cycle's stimulus pushes its expected outputs, a negedge monitor pops and compares.
module tb_id_hazard_ctrl;
`ifdef ID_HAZARD_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] EPC1 = IRQ_ON ? 32'h0040_000C : 32'd0;
    localparam logic [31:0] EPC2 = IRQ_ON ? 32'h0000_00FC : 32'd0;
    localparam logic [1:0]  SEL_IRQ  = IRQ_ON ? 2'd1 : 2'd0;
    localparam logic [1:0]  SEL_ERET = IRQ_ON ? 2'd2 : 2'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rsaddrID, rtaddrID, regwriteaddrEX, regwriteaddrMEM;
    logic        BranchID, JumpID, EretID, MemReadEX, RegWriteEX, MemReadMEM, irq;
    logic [2:0]  PCSrcID;
    logic [31:0] PCplus4ID;
    logic        stall, pc_write, ifid_write, ifid_flush, kernel, irq_ack;
    logic [1:0]  pc_sel;
    logic [31:0] epc;
    logic [31:0] stall_count;

    typedef struct packed {
        logic        stall, pcw, ifw, flush;
        logic [1:0]  sel;
        logic        ack, kern;
        logic [31:0] epc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    id_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rsaddrID(rsaddrID), .rtaddrID(rtaddrID),
        .BranchID(BranchID), .JumpID(JumpID), .PCSrcID(PCSrcID), .EretID(EretID),
        .PCplus4ID(PCplus4ID),
        .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX), .regwriteaddrEX(regwriteaddrEX),
        .MemReadMEM(MemReadMEM), .regwriteaddrMEM(regwriteaddrMEM),
        .irq(irq),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_sel(pc_sel), .epc(epc), .kernel(kernel), .irq_ack(irq_ack),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    function automatic exp_t ex(input logic s, input logic pw, input logic iw, input logic fl,
                                input logic [1:0] sel, input logic ack, input logic kern,
                                input logic [31:0] e, input logic [31:0] c);
        exp_t r;
        r.stall = s; r.pcw = pw; r.ifw = iw; r.flush = fl;
        r.sel = sel; r.ack = ack; r.kern = kern; r.epc = e; r.cnt = c;
        return r;
    endfunction

    // Wait for a negedge, return every input to idle; caller then sets this cycle's fields and pushes.
    task automatic cyc();
        @(negedge clk);
        rsaddrID = 5'd0; rtaddrID = 5'd0; BranchID = 1'b0; JumpID = 1'b0;
        PCSrcID = 3'd0; EretID = 1'b0; PCplus4ID = 32'd0;
        MemReadEX = 1'b0; RegWriteEX = 1'b0; regwriteaddrEX = 5'd0;
        MemReadMEM = 1'b0; regwriteaddrMEM = 5'd0; irq = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            $display("txn %0d: stall=%0b pcw=%0b ifw=%0b flush=%0b sel=%0d ack=%0b kernel=%0b epc=%h cnt=%0d",
                     txn, stall, pc_write, ifid_write, ifid_flush, pc_sel, irq_ack, kernel, epc, stall_count);
            chk($sformatf("t%0d.stall", txn), {31'd0, stall}, {31'd0, e.stall});
            chk($sformatf("t%0d.pc_write", txn), {31'd0, pc_write}, {31'd0, e.pcw});
            chk($sformatf("t%0d.ifid_write", txn), {31'd0, ifid_write}, {31'd0, e.ifw});
            chk($sformatf("t%0d.ifid_flush", txn), {31'd0, ifid_flush}, {31'd0, e.flush});
            chk($sformatf("t%0d.pc_sel", txn), {30'd0, pc_sel}, {30'd0, e.sel});
            chk($sformatf("t%0d.irq_ack", txn), {31'd0, irq_ack}, {31'd0, e.ack});
            chk($sformatf("t%0d.kernel", txn), {31'd0, kernel}, {31'd0, e.kern});
            chk($sformatf("t%0d.epc", txn), epc, e.epc);
            chk($sformatf("t%0d.stall_count", txn), stall_count, e.cnt);
            txn++;
        end
    end

    initial begin
        // reset held low: idle outputs
        cyc(); sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,0));
        cyc(); reset = 1'b1; sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,0));
        // load-use on rs, then idle, then load-use on rt
        cyc(); MemReadEX = 1; RegWriteEX = 1; regwriteaddrEX = 8; rsaddrID = 8; rtaddrID = 1;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,0));
        cyc(); sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,1));
        cyc(); MemReadEX = 1; RegWriteEX = 1; regwriteaddrEX = 8; rsaddrID = 1; rtaddrID = 8;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,1));
        // branch after load: two stall cycles, then taken flush
        cyc(); BranchID = 1; rsaddrID = 8; MemReadEX = 1; RegWriteEX = 1; regwriteaddrEX = 8;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,2));
        cyc(); BranchID = 1; rsaddrID = 8; MemReadMEM = 1; regwriteaddrMEM = 8;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,3));
        cyc(); BranchID = 1; rsaddrID = 8; PCSrcID = 3'd1;
        sbQ.push_back(ex(0,1,1,1,0,0,0,32'd0,4));
        // $0 destination never stalls
        cyc(); MemReadEX = 1; RegWriteEX = 1; regwriteaddrEX = 0;
        sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,4));
        // jump reading an EX result
        cyc(); JumpID = 1; RegWriteEX = 1; regwriteaddrEX = 5; rsaddrID = 5;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,4));
        // non-branch with MEM load and EX ALU dependency: forwardable, no stall
        cyc(); rsaddrID = 3; rtaddrID = 9; MemReadMEM = 1; regwriteaddrMEM = 3; RegWriteEX = 1; regwriteaddrEX = 9;
        sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,5));
        cyc(); JumpID = 1; PCSrcID = 3'd2;
        sbQ.push_back(ex(0,1,1,1,0,0,0,32'd0,5));
        // hazard beats taken-branch flush
        cyc(); BranchID = 1; PCSrcID = 3'd1; MemReadEX = 1; regwriteaddrEX = 7; rtaddrID = 7;
        sbQ.push_back(ex(1,0,0,0,0,0,0,32'd0,5));
        // irq deferred by branch, then accepted
        cyc(); irq = 1; BranchID = 1;
        sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,6));
        cyc(); irq = 1; PCplus4ID = 32'h0040_0010;
        sbQ.push_back(ex(IRQ_ON,1,1,IRQ_ON,SEL_IRQ,IRQ_ON,0,32'd0,6));
        cyc(); sbQ.push_back(ex(0,1,1,0,0,0,IRQ_ON,EPC1,6));
        // in kernel: irq ignored, ERET under hazard held, then ERET taken
        cyc(); irq = 1; PCplus4ID = 32'h0000_0200;
        sbQ.push_back(ex(0,1,1,0,0,0,IRQ_ON,EPC1,6));
        cyc(); EretID = 1; MemReadEX = 1; regwriteaddrEX = 4; rsaddrID = 4;
        sbQ.push_back(ex(1,0,0,0,0,0,IRQ_ON,EPC1,6));
        cyc(); EretID = 1;
        sbQ.push_back(ex(0,1,1,IRQ_ON,SEL_ERET,0,IRQ_ON,EPC1,7));
        cyc(); sbQ.push_back(ex(0,1,1,0,0,0,0,EPC1,7));
        // ERET in RUN is a NOP
        cyc(); EretID = 1;
        sbQ.push_back(ex(0,1,1,0,0,0,0,EPC1,7));
        // irq waits out a load-use stall
        cyc(); irq = 1; MemReadEX = 1; regwriteaddrEX = 6; rsaddrID = 6; PCplus4ID = 32'h0000_0100;
        sbQ.push_back(ex(1,0,0,0,0,0,0,EPC1,7));
        cyc(); irq = 1; PCplus4ID = 32'h0000_0100;
        sbQ.push_back(ex(IRQ_ON,1,1,IRQ_ON,SEL_IRQ,IRQ_ON,0,EPC1,8));
        cyc(); sbQ.push_back(ex(0,1,1,0,0,0,IRQ_ON,EPC2,8));
        // asynchronous reset mid-handler, sampled before any rising edge
        cyc(); reset = 1'b0;
        sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,0));
        cyc(); reset = 1'b1;
        sbQ.push_back(ex(0,1,1,0,0,0,0,32'd0,0));

        for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(posedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
